// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial add/subtract, one bit per clock LSB first, with a
// start/done handshake and results held until the next accepted operation.
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RW = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic [RW-1:0]    res;
    logic [CNT_W-1:0] cnt;
    logic             carry, sbit, carry_nxt, last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    always_comb begin
        sbit      = sa[0] ^ sb[0] ^ carry;
        carry_nxt = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        last      = cnt == CNT_W'(WIDTH - 1);
    end

    // The last bit goes straight into sum so the result is visible while done is high;
    // carry at that point is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= carry_nxt;
            res   <= RW'({sbit, res} >> 1);
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= {sbit, res};
                cout <= carry_nxt;
                ovf  <= carry ^ carry_nxt;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: directed and random checks of serial_adder_sub at WIDTH 8,
// plus random sweeps at WIDTH 2, 4 and 16, scored against an arithmetic model.
module tb_serial_adder_sub;
    logic       clk, rst, start, sub;
    logic [7:0] a, b, sum8, last8;
    logic       busy8, done8, cout8, ovf8;
    logic [33:0] q8[$];
    logic [33:0] e8;
    int         checks = 0, errors = 0;
    int         dc[$];
    int         nd;
    bit         go = 0;

    serial_adder_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {ovf, cout, sum[31:0]} from plain integer arithmetic on w-bit operands
    function automatic logic [33:0] model(input int w, input longint x, input longint y, input bit s);
        longint m, r, sx, sy, sr;
        logic [33:0] res;
        m  = 64'sd1 <<< w;
        r  = s ? x - y : x + y;
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        sr = s ? sx - sy : sx + sy;
        res[31:0] = 32'(((r % m) + m) % m);
        res[32]   = s ? (x >= y) : (r >= m);
        res[33]   = (sr < -(m / 2)) || (sr >= m / 2);
        return res;
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) check("u8_spurious_done", done8, 0);
            else begin
                e8 = q8.pop_front();
                check("u8_result", {ovf8, cout8, sum8}, {e8[33:32], e8[7:0]});
            end
        end
    end

    // Caller sits at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s, input bit mid);
        logic [33:0] e;
        e = model(8, longint'(x), longint'(y), s);
        a = x; b = y; sub = s; start = 1;
        q8.push_back(e);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1 || i == 4) start = 0;
            if (mid && i == 3) begin
                start = 1; a = ~x; b = 8'h5A; sub = ~s;
            end
            if (i <= 9) begin
                check($sformatf("busy_c%0d", i), busy8, i <= 8);
                check($sformatf("done_c%0d", i), done8, i == 9);
            end
            if (i <= 8) check($sformatf("hold_c%0d", i), sum8, last8);
        end
        last8 = e[7:0];
    endtask

    initial begin
        rst = 1; start = 1; sub = 0; a = 8'hAA; b = 8'h55; last8 = 0;
        repeat (2) begin
            @(negedge clk);
            check("reset_outs", {busy8, done8, cout8, ovf8, sum8}, 0);
        end
        rst = 0; start = 0;
        @(negedge clk);
        check("reset_no_start", {busy8, done8}, 0);

        run8(8'h3C, 8'h25, 0, 0);
        run8(8'hFF, 8'h01, 0, 0);
        run8(8'h7F, 8'h01, 0, 0);
        run8(8'h10, 8'h20, 1, 0);
        run8(8'h80, 8'h01, 1, 0);
        run8(8'h00, 8'h00, 1, 0);
        run8(8'h55, 8'h22, 0, 1);
        run8(8'hA0, 8'h0F, 1, 1);

        a = 8'h12; b = 8'h34; sub = 1; start = 1;
        repeat (3) q8.push_back(model(8, 64'h12, 64'h34, 1));
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done8) dc.push_back(i);
            if (i == 30) start = 0;
        end
        check("b2b_count", dc.size(), 3);
        check("b2b_first", dc[0], 9);
        check("b2b_gap1", dc[1] - dc[0], 10);
        check("b2b_gap2", dc[2] - dc[1], 10);
        last8 = 8'hDE;

        run8(8'hF0, 8'h20, 0, 0);
        a = 8'hC3; b = 8'h3C; sub = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_outs", {busy8, done8, cout8, ovf8, sum8}, 0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("abort_no_done", nd, 0);
        last8 = 0;

        repeat (40) run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        go = 1;
        for (int k = 0; k < 20000 && !(sw[0].fin && sw[1].fin && sw[2].fin); k++) @(negedge clk);
        check("sweep_finished", {sw[0].fin, sw[1].fin, sw[2].fin}, 3'b111);
        check("u8_queue_empty", q8.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = (g == 0) ? 2 : (g == 1) ? 4 : 16;
        logic         start_s, sub_s, busy_s, done_s, cout_s, ovf_s;
        logic [W-1:0] a_s, b_s, sum_s;
        logic [33:0]  q[$];
        logic [33:0]  e;
        bit           fin = 0;

        serial_adder_sub #(.WIDTH(W)) u (
            .clk(clk), .rst(rst), .start(start_s), .sub(sub_s), .a(a_s), .b(b_s),
            .busy(busy_s), .done(done_s), .sum(sum_s), .cout(cout_s), .ovf(ovf_s)
        );

        initial begin
            start_s = 0; sub_s = 0; a_s = '0; b_s = '0;
            wait (go);
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                a_s = W'($urandom); b_s = W'($urandom); sub_s = 1'($urandom); start_s = 1;
                q.push_back(model(W, longint'(a_s), longint'(b_s), sub_s));
                @(negedge clk);
                start_s = 0;
                for (int k = 0; k < W + 3 && !done_s; k++) @(negedge clk);
                check($sformatf("w%0d_done_seen", W), done_s, 1);
            end
            repeat (2) @(negedge clk);
            check($sformatf("w%0d_queue_empty", W), q.size(), 0);
            fin = 1;
        end

        always @(negedge clk) begin
            if (done_s) begin
                if (q.size() == 0) check($sformatf("w%0d_spurious_done", W), done_s, 0);
                else begin
                    e = q.pop_front();
                    check($sformatf("w%0d_result", W), {ovf_s, cout_s, sum_s}, {e[33:32], e[W-1:0]});
                end
            end
        end
    end
endmodule
